// File: rtl/pn_sequence_sync.sv
`default_nettype none
// =============================================================================
// pn_sequence_sync : self-synchronising PN chip receiver (acquire, flywheel,
//                    lock/sync/bit-error reporting, saturating error count)
// Revision 1.0
// =============================================================================
module pn_sequence_sync #(
  parameter int             M           = 5,
  parameter logic [M-1:0]   TAPS        = 5'b10100,
  parameter logic [M-1:0]   SYNC_STATE  = 5'b11111,
  parameter int             LOCK_COUNT  = 16,
  parameter int             WINDOW      = 32,
  parameter int             LOSS_THRESH = 4,
  parameter int             ERR_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic             clear_errors_i,
  output logic             locked_o,
  output logic             sync_bit_o,
  output logic             ref_bit_o,
  output logic             bit_error_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam int FILL_W  = $clog2(M + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(M);
  localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]   WIN_END    = WIN_W'(WINDOW);
  localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [M-1:0]       s_q, s_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               ref_q, ref_d;
  logic               sync_q, sync_d;
  logic               berr_q, berr_d;

  logic               pred;
  logic               mismatch;
  logic [WERR_W-1:0]  werr_n;

  assign pred     = ^(s_q & TAPS);
  assign mismatch = (in_bit_i != pred);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = err_q;
    ref_d   = ref_q;
    sync_d  = 1'b0;
    berr_d  = 1'b0;
    werr_n  = werr_q + WERR_W'(mismatch);

    if (in_valid_i) begin
      ref_d = pred;
      unique case (state_q)
        ST_SEARCH: begin
          s_d    = {s_q[M-2:0], in_bit_i};
          fill_d = fill_q + 1'b1;
          if (fill_d == FILL_DONE) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end
        ST_VERIFY: begin
          s_d = {s_q[M-2:0], in_bit_i};
          // An all-zero register predicts zeros forever and must never count.
          if ((s_q == '0) || mismatch) begin
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
            if (match_d == MATCH_DONE) begin
              state_d = ST_LOCKED;
              err_d   = '0;
              win_d   = '0;
              werr_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          s_d    = {s_q[M-2:0], pred};
          sync_d = ({s_q[M-2:0], pred} == SYNC_STATE);
          win_d  = win_q + 1'b1;
          werr_d = werr_n;
          if (mismatch) begin
            berr_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          // The error on the final bit of a window still belongs to that window.
          if (win_d == WIN_END) begin
            win_d  = '0;
            werr_d = '0;
          end
          if (werr_n == WERR_LOSS) begin
            state_d = ST_SEARCH;
            fill_d  = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (clear_errors_i) err_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SEARCH;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      ref_q   <= 1'b0;
      sync_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      ref_q   <= ref_d;
      sync_q  <= sync_d;
      berr_q  <= berr_d;
    end
  end

  assign locked_o    = (state_q == ST_LOCKED);
  assign sync_bit_o  = sync_q;
  assign ref_bit_o   = ref_q;
  assign bit_error_o = berr_q;
  assign err_count_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pn_sequence_sync.sv
`default_nettype none
// tb_pn_sequence_sync : randomized and directed checks of pn_sequence_sync
// against a chip-history reference model.
module tb_pn_sequence_sync;

  localparam int         M           = 5;
  localparam logic [4:0] TAPS        = 5'b10100;
  localparam logic [4:0] SYNC        = 5'b11111;
  localparam int         LOCK_COUNT  = 16;
  localparam int         WINDOW      = 32;
  localparam int         LOSS_THRESH = 4;
  localparam int         ERR_W       = 16;
  localparam int         ERR_MAX     = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clear_errors = 1'b0;
  logic locked, sync_bit, ref_bit, bit_error;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  pn_sequence_sync #(
    .M(M), .TAPS(TAPS), .SYNC_STATE(SYNC), .LOCK_COUNT(LOCK_COUNT),
    .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_bit_i(in_bit),
    .clear_errors_i(clear_errors), .locked_o(locked), .sync_bit_o(sync_bit),
    .ref_bit_o(ref_bit), .bit_error_o(bit_error), .err_count_o(err_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 search, 1 verify, 2 locked; hs[0] is the newest chip.
  int m_mode, m_fill, m_match, m_win, m_werr, m_errc;
  bit hs[M];
  bit e_ref, e_sync, e_berr;

  bit gen[$];   // transmitter chip history
  int vbit;     // valid chips presented since start

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pn_next();
    bit c;
    c = 1'b0;
    for (int i = 0; i < M; i++)
      if (TAPS[i]) c ^= gen[gen.size()-1-i];
    gen.push_back(c);
    if (gen.size() > 64) void'(gen.pop_front());
    return c;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_errc = 0;
    for (int i = 0; i < M; i++) hs[i] = 1'b0;
    e_ref = 1'b0; e_sync = 1'b0; e_berr = 1'b0;
  endfunction

  function automatic void push_hist(input bit x);
    for (int i = M-1; i > 0; i--) hs[i] = hs[i-1];
    hs[0] = x;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit c);
    bit p, zero, at_sync, lost;
    e_sync = 1'b0;
    e_berr = 1'b0;
    if (v) begin
      p = 1'b0;
      zero = 1'b1;
      for (int i = 0; i < M; i++) begin
        if (TAPS[i]) p ^= hs[i];
        if (hs[i]) zero = 1'b0;
      end
      e_ref = p;
      if (m_mode == 0) begin
        push_hist(b);
        m_fill++;
        if (m_fill == M) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        push_hist(b);
        if (zero || b != p) m_match = 0;
        else begin
          m_match++;
          if (m_match == LOCK_COUNT) begin
            m_mode = 2; m_errc = 0; m_win = 0; m_werr = 0;
          end
        end
      end else begin
        push_hist(p);
        if (b != p) begin
          e_berr = 1'b1;
          if (m_errc < ERR_MAX) m_errc++;
          m_werr++;
        end
        at_sync = 1'b1;
        for (int i = 0; i < M; i++) if (hs[i] != SYNC[i]) at_sync = 1'b0;
        e_sync = at_sync;
        m_win++;
        lost = (m_werr >= LOSS_THRESH);
        if (m_win == WINDOW) begin m_win = 0; m_werr = 0; end
        if (lost) begin m_mode = 0; m_fill = 0; end
      end
    end
    if (c) m_errc = 0;
  endfunction

  task automatic step(input bit v, input bit b, input bit c);
    in_valid = v; in_bit = b; clear_errors = c;
    model_step(v, b, c);
    @(posedge clk); #1;
    if (v) vbit++;
    chk("locked", locked, (m_mode == 2));
    chk("sync_bit", sync_bit, e_sync);
    chk("ref_bit", ref_bit, e_ref);
    chk("bit_error", bit_error, e_berr);
    chk("err_count", err_count, m_errc);
  endtask

  task automatic reset_now();
    in_valid = 1'b0; clear_errors = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_sync", sync_bit, 0);
    chk("rst_ref", ref_bit, 0);
    chk("rst_berr", bit_error, 0);
    chk("rst_errcnt", err_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Feed a clean stream (optionally one flipped chip) until lock; returns chips used.
  task automatic run_to_lock(input int flip_at, output int n_bits, output int n_berr);
    n_bits = 0; n_berr = 0;
    for (int n = 1; n <= 100; n++) begin
      step(1'b1, pn_next() ^ (n == flip_at), 1'b0);
      if (bit_error) n_berr++;
      if (locked) begin n_bits = n; break; end
    end
  endtask

  task automatic wait_window_start();
    for (int k = 0; k < 40 && m_win != 0; k++) step(1'b1, pn_next(), 1'b0);
  endtask

  initial begin
    int nb, ne, nsync, last_sv, idle_sync, ref_bad, berr_cnt;
    vbit = 0;
    model_reset();
    gen.push_back(1'b1); gen.push_back(1'b0); gen.push_back(1'b1);
    gen.push_back(1'b1); gen.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("por_locked", locked, 0);
    chk("por_errcnt", err_count, 0);
    chk("por_sync", sync_bit, 0);
    rst_n = 1'b1;

    // Acquisition on a clean stream: 5 fill chips plus 16 correct predictions.
    run_to_lock(0, nb, ne);
    chk("lock_bit", nb, 21);
    chk("acq_berr", ne, 0);

    // Flywheel: 93 chips hold exactly three periods.
    nsync = 0; last_sv = -1; ref_bad = 0;
    for (int n = 0; n < 93; n++) begin
      bit c;
      c = pn_next();
      step(1'b1, c, 1'b0);
      if (ref_bit != c) ref_bad++;
      if (sync_bit) begin
        if (last_sv >= 0) chk("sync_spacing", vbit - last_sv, 31);
        last_sv = vbit;
        nsync++;
      end
    end
    chk("sync_count", nsync, 3);
    chk("ref_vs_stream", ref_bad, 0);

    nsync = 0; idle_sync = 0;
    for (int n = 0; n < 93; n++) begin
      step(1'b1, pn_next(), 1'b0);
      if (sync_bit) nsync++;
      repeat (2) begin
        step(1'b0, 1'($urandom), 1'b0);
        if (sync_bit) idle_sync++;
      end
    end
    chk("sync_count_gapped", nsync, 3);
    chk("sync_on_idle", idle_sync, 0);

    // Three errors inside one window: counted, lock kept.
    wait_window_start();
    berr_cnt = 0;
    for (int k = 0; k < WINDOW; k++) begin
      step(1'b1, pn_next() ^ (k == 3 || k == 10 || k == 20), 1'b0);
      if (bit_error) berr_cnt++;
    end
    chk("t4_berr_pulses", berr_cnt, 3);
    chk("t4_errcnt", err_count, 3);
    chk("t4_locked", locked, 1);
    step(1'b1, ~pn_next(), 1'b1);
    chk("t4_clear_wins", err_count, 0);

    // Four errors inside one window: lock drops right after the fourth.
    wait_window_start();
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("t5_locked_before", locked, 1);
      step(1'b1, pn_next() ^ (k[0] == 1'b1), 1'b0);
    end
    chk("t5_locked_after", locked, 0);
    chk("t5_errcnt_held", err_count, 4);
    run_to_lock(0, nb, ne);
    chk("t5_relock_bits", nb, 21);
    chk("t5_errcnt_relock", err_count, 0);

    // Asynchronous reset while locked.
    chk("t1_locked_pre", locked, 1);
    reset_now();

    // All-zero stream never locks.
    nb = 0;
    for (int n = 0; n < 100; n++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) nb++;
    end
    chk("zero_stream_locked", nb, 0);

    // A bad chip at 12 also sits in the register and spoils the predictions of
    // chips 15 and 17, so the 16-long clean run ends at chip 33.
    reset_now();
    run_to_lock(12, nb, ne);
    chk("t6_lock_bit", nb, 33);

    // Randomized traffic: gaps, chip errors, clears, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      bit v, f, c;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 149) == 0);
      if (n == 1500) reset_now();
      if (v) step(1'b1, pn_next() ^ f, c);
      else   step(1'b0, 1'($urandom), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
